// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Memory-access stage. Turns a decoded load/store (memRW, func3,
//             ALU address, rs2 data) into one request/ready data-memory bus
//             transaction. It stalls the core while the access is in flight,
//             returns sign/zero-extended load data, and flags misaligned,
//             illegal or timed-out accesses.
//  Ports    : clk, rst_n            clock / asynchronous active-low reset
//             memRW, func3          decoded access type and size/sign
//             addr, store_data      byte address and rs2 value
//             stall                 hold the pipeline this cycle (comb)
//             load_data/load_valid  extended load result + 1-cycle strobe
//             access_err            1-cycle strobe: rejected or aborted
//             mem_req/we/addr/wdata/be, mem_ready, mem_rdata  data bus
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 16  // 1..255 BUSY cycles before abort
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  memRW,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  // --------------------------------------------------------------------------
  // Encodings
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_RW_READ  = 2'b01;
  localparam logic [1:0] c_RW_WRITE = 2'b10;

  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;

  // The counter value seen in the last allowed wait cycle: when a BUSY cycle
  // without mem_ready starts with this count, it is the MAX_WAIT-th such
  // cycle and the access is abandoned.
  localparam logic [7:0] c_WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_wait_cnt;

  // Access attributes latched at accept time for the load extractor.
  logic [2:0]  r_func3;
  logic [1:0]  r_off;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic [31:0] r_load_data;
  logic        r_load_valid;
  logic        r_access_err;

  logic        w_is_rd;
  logic        w_is_wr;
  logic        w_f3_legal;
  logic        w_aligned;
  logic        w_accept;
  logic        w_reject;
  logic        w_complete;
  logic        w_timeout;

  logic [31:0] w_lane_wdata;
  logic [3:0]  w_lane_be;
  logic [31:0] w_load_ext;
  logic [7:0]  w_rd_byte;
  logic [15:0] w_rd_half;

  // --------------------------------------------------------------------------
  // Request decode and legality
  // --------------------------------------------------------------------------
  assign w_is_rd = (memRW == c_RW_READ);
  assign w_is_wr = (memRW == c_RW_WRITE);

  always_comb begin
    w_f3_legal = 1'b0;
    w_aligned  = 1'b0;
    unique case (func3)
      c_F3_B, c_F3_BU: begin
        // Unsigned variants exist only for loads.
        w_f3_legal = (func3 == c_F3_B) || w_is_rd;
        w_aligned  = 1'b1;
      end
      c_F3_H, c_F3_HU: begin
        w_f3_legal = (func3 == c_F3_H) || w_is_rd;
        w_aligned  = (addr[0] == 1'b0);
      end
      c_F3_W: begin
        w_f3_legal = 1'b1;
        w_aligned  = (addr[1:0] == 2'b00);
      end
      default: begin
        w_f3_legal = 1'b0;
        w_aligned  = 1'b0;
      end
    endcase
  end

  assign w_accept   = (r_state == ST_IDLE) && (w_is_rd || w_is_wr) &&
                      w_f3_legal && w_aligned;
  assign w_reject   = (r_state == ST_IDLE) && (w_is_rd || w_is_wr) &&
                      !(w_f3_legal && w_aligned);
  assign w_complete = (r_state == ST_BUSY) && mem_ready;
  assign w_timeout  = (r_state == ST_BUSY) && !mem_ready &&
                      (r_wait_cnt == c_WAIT_LAST);

  // --------------------------------------------------------------------------
  // Store lane replication and byte enables
  // --------------------------------------------------------------------------
  always_comb begin
    w_lane_wdata = store_data;
    w_lane_be    = 4'b0000;
    unique case (func3[1:0])
      2'b00: begin
        w_lane_wdata = {4{store_data[7:0]}};
        w_lane_be    = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        w_lane_wdata = {2{store_data[15:0]}};
        w_lane_be    = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_lane_wdata = store_data;
        w_lane_be    = 4'b1111;
      end
    endcase
    // Reads never present byte enables on the bus.
    if (!w_is_wr) begin
      w_lane_be = 4'b0000;
    end
  end

  // --------------------------------------------------------------------------
  // Load extraction from the returned word
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_byte = mem_rdata[7:0];
    unique case (r_off)
      2'b00:   w_rd_byte = mem_rdata[7:0];
      2'b01:   w_rd_byte = mem_rdata[15:8];
      2'b10:   w_rd_byte = mem_rdata[23:16];
      default: w_rd_byte = mem_rdata[31:24];
    endcase
    w_rd_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    w_load_ext = mem_rdata;
    unique case (r_func3)
      c_F3_B:  w_load_ext = {{24{w_rd_byte[7]}}, w_rd_byte};
      c_F3_BU: w_load_ext = {24'h000000, w_rd_byte};
      c_F3_H:  w_load_ext = {{16{w_rd_half[15]}}, w_rd_half};
      c_F3_HU: w_load_ext = {16'h0000, w_rd_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and stall
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_BUSY;
          stall        = 1'b1;
        end
      end
      ST_BUSY: begin
        // The abort cycle releases the pipeline so the core can move on.
        stall = !w_timeout;
        if (w_complete) begin
          w_next_state = ST_DONE;
        end else if (w_timeout) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_DONE: begin
        // memRW still belongs to the finishing instruction; do not re-accept.
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Wait counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if (w_accept || r_state != ST_BUSY) begin
      r_wait_cnt <= 8'd0;
    end else if (!mem_ready) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Bus request fields: loaded at accept, stable while BUSY
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
      r_mem_be    <= 4'b0000;
      r_func3     <= 3'b000;
      r_off       <= 2'b00;
    end else if (w_accept) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= w_is_wr;
      r_mem_addr  <= {addr[31:2], 2'b00};
      r_mem_wdata <= w_lane_wdata;
      r_mem_be    <= w_lane_be;
      r_func3     <= func3;
      r_off       <= addr[1:0];
    end else if (w_complete || w_timeout) begin
      r_mem_req   <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Load result and status strobes
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_data  <= 32'h0000_0000;
      r_load_valid <= 1'b0;
      r_access_err <= 1'b0;
    end else begin
      r_load_valid <= w_complete && !r_mem_we;
      r_access_err <= w_reject || w_timeout;
      if (w_complete && !r_mem_we) begin
        r_load_data <= w_load_ext;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_be     = r_mem_be;
  assign load_data  = r_load_data;
  assign load_valid = r_load_valid;
  assign access_err = r_access_err;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Directed table-driven bench for load_store_unit, with a small
//             bus responder and hand-written reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  memRW = 2'b00;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        access_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_load = 32'h0;

  load_store_unit #(.MAX_WAIT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memRW      (memRW),
    .func3      (func3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .access_err (access_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  rw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          delay;      // req cycles before mem_ready (255 = never)
    int          exp_req;    // cycles mem_req high
    int          exp_stall;  // cycles stall high
    int          exp_err;    // access_err pulses
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_lv;     // load_valid pulses
    logic [31:0] exp_ld;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [1:0] rw, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                              input int dly, input int ereq, input int estall, input int eerr,
                              input logic [31:0] eaddr, input logic [3:0] ebe,
                              input logic [31:0] ewd, input int elv, input logic [31:0] eld);
    vec_t v;
    v.name = name; v.rw = rw; v.f3 = f3; v.addr = a; v.sd = sd; v.rdata = rd;
    v.delay = dly; v.exp_req = ereq; v.exp_stall = estall; v.exp_err = eerr;
    v.exp_addr = eaddr; v.exp_be = ebe; v.exp_wdata = ewd; v.exp_lv = elv; v.exp_ld = eld;
    return v;
  endfunction

  // Present one instruction, answer the bus after v.delay request cycles,
  // retire the instruction after its first non-stalled cycle, and check.
  task automatic run_vec(input vec_t v);
    int stall_cnt = 0, req_cnt = 0, err_cnt = 0, lv_cnt = 0, waited = 0, unstable = 0;
    int both = 0;
    logic pend = 1'b0;
    logic first = 1'b1;
    logic [31:0] ld_seen = 32'h0, f_addr = 32'h0, f_wd = 32'h0;
    logic [3:0]  f_be = 4'h0;
    logic        f_we = 1'b0;
    @(negedge clk);
    memRW = v.rw; func3 = v.f3; addr = v.addr; store_data = v.sd;
    mem_rdata = v.rdata; mem_ready = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (pend) memRW = 2'b00;
      end
      #1;
      if (stall) stall_cnt++; else pend = 1'b1;
      if (access_err) err_cnt++;
      if (load_valid) begin lv_cnt++; ld_seen = load_data; end
      if (access_err && load_valid) both++;
      if (mem_req) begin
        req_cnt++;
        if (first) begin
          first = 1'b0;
          f_addr = mem_addr; f_we = mem_we; f_be = mem_be; f_wd = mem_wdata;
        end else if (mem_addr !== f_addr || mem_we !== f_we || mem_be !== f_be ||
                     mem_wdata !== f_wd) begin
          unstable++;
        end
        if (waited == v.delay) mem_ready = 1'b1;
        else begin waited++; mem_ready = 1'b0; end
      end else begin
        mem_ready = 1'b0;
      end
    end
    mem_ready = 1'b0;
    if (v.exp_lv != 0) last_load = v.exp_ld;
    chk({v.name, " stall_cycles"}, stall_cnt, v.exp_stall);
    chk({v.name, " req_cycles"}, req_cnt, v.exp_req);
    chk({v.name, " access_err_pulses"}, err_cnt, v.exp_err);
    chk({v.name, " load_valid_pulses"}, lv_cnt, v.exp_lv);
    chk({v.name, " err_and_lv_together"}, both, 0);
    if (v.exp_req > 0) begin
      chk({v.name, " mem_addr"}, f_addr, v.exp_addr);
      chk({v.name, " mem_we"}, {31'h0, f_we}, {31'h0, (v.rw == 2'b10)});
      chk({v.name, " mem_be"}, {28'h0, f_be}, {28'h0, v.exp_be});
      if (v.rw == 2'b10) chk({v.name, " mem_wdata"}, f_wd, v.exp_wdata);
      chk({v.name, " bus_stable"}, unstable, 0);
    end
    if (v.exp_lv != 0) chk({v.name, " load_data_at_valid"}, ld_seen, v.exp_ld);
    chk({v.name, " load_data_held"}, load_data, last_load);
  endtask

  vec_t vecs[18];

  initial begin
    //          name         rw     f3      addr          store         rdata         dly req stl err exp_addr      be      wdata         lv ld
    vecs[0]  = mk("LW",      2'b01, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0,  1,  2,  0, 32'h0000_0100, 4'h0, 32'h0,        1, 32'hDEADBEEF);
    vecs[1]  = mk("LB",      2'b01, 3'b000, 32'h0000_0103, 32'h0,        32'h80112233, 0,  1,  2,  0, 32'h0000_0100, 4'h0, 32'h0,        1, 32'hFFFFFF80);
    vecs[2]  = mk("LBU",     2'b01, 3'b100, 32'h0000_0103, 32'h0,        32'h80112233, 0,  1,  2,  0, 32'h0000_0100, 4'h0, 32'h0,        1, 32'h00000080);
    vecs[3]  = mk("LHU",     2'b01, 3'b101, 32'h0000_0102, 32'h0,        32'h80112233, 0,  1,  2,  0, 32'h0000_0100, 4'h0, 32'h0,        1, 32'h00008011);
    vecs[4]  = mk("LH_hi",   2'b01, 3'b001, 32'h0000_0102, 32'h0,        32'h80112233, 1,  2,  3,  0, 32'h0000_0100, 4'h0, 32'h0,        1, 32'hFFFF8011);
    vecs[5]  = mk("LH_lo",   2'b01, 3'b001, 32'h0000_0100, 32'h0,        32'h80112233, 0,  1,  2,  0, 32'h0000_0100, 4'h0, 32'h0,        1, 32'h00002233);
    vecs[6]  = mk("LB_wait", 2'b01, 3'b000, 32'h0000_0101, 32'h0,        32'h80112233, 2,  3,  4,  0, 32'h0000_0100, 4'h0, 32'h0,        1, 32'h00000022);
    vecs[7]  = mk("SB",      2'b10, 3'b000, 32'h0000_0201, 32'h000000A5, 32'h0,        0,  1,  2,  0, 32'h0000_0200, 4'h2, 32'hA5A5A5A5, 0, 32'h0);
    vecs[8]  = mk("SH",      2'b10, 3'b001, 32'h0000_0202, 32'h1234BEEF, 32'h0,        1,  2,  3,  0, 32'h0000_0200, 4'hC, 32'hBEEFBEEF, 0, 32'h0);
    vecs[9]  = mk("SW",      2'b10, 3'b010, 32'h0000_0204, 32'hCAFEF00D, 32'h0,        0,  1,  2,  0, 32'h0000_0204, 4'hF, 32'hCAFEF00D, 0, 32'h0);
    vecs[10] = mk("LW_wait", 2'b01, 3'b010, 32'h0000_010C, 32'h0,        32'h12345678, 3,  4,  5,  0, 32'h0000_010C, 4'h0, 32'h0,        1, 32'h12345678);
    vecs[11] = mk("LH_mis",  2'b01, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0,  0,  0,  1, 32'h0,         4'h0, 32'h0,        0, 32'h0);
    vecs[12] = mk("LD_f011", 2'b01, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0,  0,  0,  1, 32'h0,         4'h0, 32'h0,        0, 32'h0);
    vecs[13] = mk("SW_mis",  2'b10, 3'b010, 32'h0000_0102, 32'h11111111, 32'h0,        0,  0,  0,  1, 32'h0,         4'h0, 32'h0,        0, 32'h0);
    vecs[14] = mk("SBU_ill", 2'b10, 3'b100, 32'h0000_0200, 32'h11111111, 32'h0,        0,  0,  0,  1, 32'h0,         4'h0, 32'h0,        0, 32'h0);
    vecs[15] = mk("RW11",    2'b11, 3'b010, 32'h0000_0100, 32'h0,        32'h0,        0,  0,  0,  0, 32'h0,         4'h0, 32'h0,        0, 32'h0);
    vecs[16] = mk("SW_tmo",  2'b10, 3'b010, 32'h0000_0300, 32'h55AA55AA, 32'h0,        255, 16, 16, 1, 32'h0000_0300, 4'hF, 32'h55AA55AA, 0, 32'h0);
    vecs[17] = mk("SB_b3",   2'b10, 3'b000, 32'h0000_0203, 32'h0000003C, 32'h0,        0,  1,  2,  0, 32'h0000_0200, 4'h8, 32'h3C3C3C3C, 0, 32'h0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset mem_req", {31'h0, mem_req}, 32'h0);
    chk("reset stall", {31'h0, stall}, 32'h0);
    chk("reset load_valid", {31'h0, load_valid}, 32'h0);
    chk("reset access_err", {31'h0, access_err}, 32'h0);
    chk("reset load_data", load_data, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_be", {28'h0, mem_be}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_vec(vecs[i]);
    end

    // Reset while an access is outstanding.
    begin
      int k = 0;
      @(negedge clk);
      memRW = 2'b01; func3 = 3'b010; addr = 32'h0000_0400; mem_rdata = 32'h0BADF00D;
      mem_ready = 1'b0;
      while (!mem_req && k < 5) begin
        @(negedge clk);
        #1;
        k++;
      end
      chk("rst_busy req_seen", {31'h0, mem_req}, 32'h1);
      memRW = 2'b00;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy mem_req_dropped", {31'h0, mem_req}, 32'h0);
      chk("rst_busy stall", {31'h0, stall}, 32'h0);
      chk("rst_busy load_data_cleared", load_data, 32'h0);
      last_load = 32'h0;
      k = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        #1;
        if (load_valid || mem_req) k++;
      end
      chk("rst_busy no_activity", k, 0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    run_vec(mk("LW_after_rst", 2'b01, 3'b010, 32'h0000_0400, 32'h0, 32'hFEEDC0DE,
               0, 1, 2, 0, 32'h0000_0400, 4'h0, 32'h0, 1, 32'hFEEDC0DE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the control decoder; consumes decoded memRW plus func3, ALU address and rs2 store data.
- Drives a single-port request/ready data-memory bus; stalls the core while the access is outstanding.
- Returns byte/half/word load data, sign- or zero-extended, to the write-back mux (WBsel = data memory).
- Flags misaligned, illegal or timed-out accesses.

Parameters:
MAX_WAIT, 16, cycles in BUSY without mem_ready before abort; legal range 1..255.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
memRW  input  2  01 read, 10 write, 00/11 no access
func3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  input  32  byte address from ALU
store_data  input  32  rs2 value
stall  output  1  hold the pipeline this cycle
load_data  output  32  extended load result
load_valid  output  1  one-cycle pulse, load_data valid
access_err  output  1  one-cycle pulse, access rejected or aborted
mem_req  output  1  bus request, held until accepted
mem_we  output  1  1 = write
mem_addr  output  32  word address, {addr[31:2],2'b00}
mem_wdata  output  32  lane-replicated store data
mem_be  output  4  byte enables (writes only; 4'b0000 on reads)
mem_ready  input  1  bus accepts/completes access this cycle
mem_rdata  input  32  read word, valid when mem_ready=1 on a read

Behaviour:
- Reset (async, rst_n=0): state IDLE; wait counter 0; all registered outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, load_data, load_valid, access_err. Asserting rst_n mid-access drops mem_req immediately and discards the access.
- FSM states: IDLE, BUSY, DONE.
- IDLE, memRW is 01 or 10:
  - Legality: func3 must be in the legal set (stores: 000/001/010 only). H needs addr[0]=0; W needs addr[1:0]=00.
  - Legal: register mem_addr, mem_we, mem_be and mem_wdata; mem_req<=1; go to BUSY. stall=1 combinationally in this cycle.
  - Illegal or misaligned: no bus activity; access_err=1 next cycle; stall=0; stay IDLE.
- IDLE, memRW 00/11: idle; stall=0.
- BUSY: stall=1; mem_req held with all bus fields stable.
  - mem_ready=1: mem_req<=0. For a read, capture the extracted byte/half/word of mem_rdata into load_data. Go to DONE.
  - Otherwise the wait counter increments. When it reaches MAX_WAIT, mem_req<=0, access_err pulses and the FSM returns to IDLE. In the abort cycle stall=0 so the pipeline proceeds.
- DONE: one cycle; stall=0; load_valid=1 only for reads. The memRW still presented this cycle belongs to the completing instruction and is not re-accepted. Next state IDLE.
- Latency: accept cycle T, mem_req high from T+1. With mem_ready at T+1: DONE at T+2, so stall is high for 2 cycles. Each extra wait cycle adds 1.
- Store lanes:
  - SB: mem_wdata = {4{store_data[7:0]}}, mem_be = 4'b0001 << addr[1:0].
  - SH: mem_wdata = {2{store_data[15:0]}}, mem_be = addr[1] ? 1100 : 0011.
  - SW: mem_wdata = store_data, mem_be = 1111.
- Load extract:
  - Byte select by addr[1:0]; half select by addr[1].
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- load_data holds its value until the next completed read.
- access_err and load_valid are never high in the same cycle.

Test Plan:
- LW addr 0x100, mem_ready at first req cycle, mem_rdata 0xDEADBEEF -> mem_addr 0x100, mem_be 0000; stall 2 cycles; load_valid with load_data 0xDEADBEEF.
- LB addr 0x103 with rdata 0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
- SB addr 0x201 with store_data 0x000000A5 -> mem_wdata 0xA5A5A5A5, mem_be 0010, mem_we 1; no load_valid.
- LH addr 0x101 -> access_err pulse, mem_req never asserts, stall 0. Repeat for func3=011 read: same result.
- SW with mem_ready held 0, MAX_WAIT=16 -> mem_req high 16 cycles, then access_err pulse, mem_req 0, state IDLE.
- rst_n low in BUSY -> mem_req 0 immediately, no load_valid. After release, a new LW completes normally.
